// File: rtl/clock_pkg.sv
// Shared types and default timing constants for the clock-setting front ends
// (seconds, minutes and hours controllers).
package clock_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STEP   = 3'd1,
    WAIT   = 3'd2,
    STEP_R = 3'd3,
    REPEAT = 3'd4,
    LOCK   = 3'd5
  } set_state_t;

  localparam int unsigned CLK_FREQ_HZ_DEF    = 32'd50_000_000;
  localparam int unsigned DEBOUNCE_CYC_DEF   = 32'd1_000_000;
  localparam int unsigned REPEAT_DLY_CYC_DEF = 32'd25_000_000;
  localparam int unsigned REPEAT_CYC_DEF     = 32'd5_000_000;

  // A counter that stops at n-1 needs $clog2(n) bits; keep at least one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 32'd2) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter for one raw push-button.
// db_nxt is the level db takes at the next edge, letting the caller prepare one cycle ahead.
module btn_debounce
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic db,
  output logic db_nxt
);

  localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 32'd1);

  logic          sync1_q;
  logic          sync2_q;
  logic          db_q;
  logic          db_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The level only follows the synced input after it has disagreed for DEBOUNCE_CYC cycles in a row.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d  = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db     = db_q;
  assign db_nxt = db_d;

endmodule

// File: rtl/sec_tick_ctrl.sv
// Seconds-counter front end: 1 Hz step pulses in RUN, debounced button steps with
// auto-repeat in SET, plus the registered up/down direction for count_second.
module sec_tick_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ    = CLK_FREQ_HZ_DEF,
  parameter int unsigned DEBOUNCE_CYC   = DEBOUNCE_CYC_DEF,
  parameter int unsigned REPEAT_DLY_CYC = REPEAT_DLY_CYC_DEF,
  parameter int unsigned REPEAT_CYC     = REPEAT_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic btn_up,
  input  logic btn_down,
  output logic en_s,
  output logic up,
  output logic down
);

  localparam int unsigned   PW         = cnt_width(CLK_FREQ_HZ);
  localparam int unsigned   DW         = cnt_width(REPEAT_DLY_CYC);
  localparam int unsigned   RW         = cnt_width(REPEAT_CYC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ_HZ - 32'd1);
  localparam logic [DW-1:0] DLY_LAST   = DW'(REPEAT_DLY_CYC - 32'd1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_CYC - 32'd1);

  logic          db_up_s;
  logic          db_dn_s;
  logic          db_up_nxt_s;
  logic          db_dn_nxt_s;
  logic          rise_up_s;
  logic          rise_dn_s;
  logic          nxt_rise_up_s;
  logic          nxt_rise_dn_s;
  logic          held_s;
  logic          other_s;

  logic [PW-1:0] presc_q,    presc_d;
  logic [DW-1:0] dly_q,      dly_d;
  logic [RW-1:0] rate_q,     rate_d;
  set_state_t    state_q,    state_d;
  logic          prev_up_q,  prev_up_d;
  logic          prev_dn_q,  prev_dn_d;
  logic          run_prev_q, run_prev_d;
  logic          en_s_q,     en_s_d;
  logic          up_q,       up_d;
  logic          down_q,     down_d;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_up),
    .db     (db_up_s),
    .db_nxt (db_up_nxt_s)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_dn (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_down),
    .db     (db_dn_s),
    .db_nxt (db_dn_nxt_s)
  );

  assign rise_up_s     = db_up_s & ~prev_up_q;
  assign rise_dn_s     = db_dn_s & ~prev_dn_q;
  assign nxt_rise_up_s = db_up_nxt_s & ~db_up_s;
  assign nxt_rise_dn_s = db_dn_nxt_s & ~db_dn_s;
  assign held_s        = up_q ? db_up_s : db_dn_s;
  assign other_s       = up_q ? db_dn_s : db_up_s;

  // Prescaler, SET FSM and next values of the registered outputs.
  always_comb begin
    presc_d    = presc_q;
    dly_d      = dly_q;
    rate_d     = rate_q;
    state_d    = state_q;
    up_d       = up_q;
    down_d     = down_q;
    en_s_d     = 1'b0;
    prev_up_d  = db_up_s;
    prev_dn_d  = db_dn_s;
    run_prev_d = run;
    if (run) begin
      state_d = IDLE;
      dly_d   = '0;
      rate_d  = '0;
      up_d    = 1'b1;
      down_d  = 1'b0;
      if (!run_prev_q || (presc_q == PRESC_LAST)) begin
        presc_d = '0;
      end else begin
        presc_d = presc_q + PW'(1);
      end
      en_s_d = (presc_d == PRESC_LAST);
    end else begin
      presc_d = '0;
      if (run_prev_q) begin
        // A button already down when SET is entered must be released before it counts.
        state_d = (db_up_s || db_dn_s) ? LOCK : IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (rise_up_s && rise_dn_s) begin
              state_d = LOCK;
            end else if (rise_up_s || rise_dn_s) begin
              state_d = STEP;
            end else begin
              state_d = IDLE;
            end
          end
          STEP: begin
            state_d = WAIT;
            dly_d   = '0;
          end
          WAIT: begin
            if (!held_s || other_s) begin
              state_d = LOCK;
            end else if (dly_q == DLY_LAST) begin
              state_d = STEP_R;
            end else begin
              dly_d = dly_q + DW'(1);
            end
          end
          STEP_R: begin
            state_d = REPEAT;
            rate_d  = '0;
          end
          REPEAT: begin
            if (!held_s || other_s) begin
              state_d = LOCK;
            end else if (rate_q == RATE_LAST) begin
              state_d = STEP_R;
            end else begin
              rate_d = rate_q + RW'(1);
            end
          end
          LOCK: begin
            if (!db_up_s && !db_dn_s) begin
              state_d = IDLE;
            end else begin
              state_d = LOCK;
            end
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
      // Latch the direction one cycle before the STEP pulse so it is settled when en_s rises.
      if ((state_d == IDLE) && (nxt_rise_up_s ^ nxt_rise_dn_s)) begin
        up_d   = nxt_rise_up_s;
        down_d = nxt_rise_dn_s;
      end else begin
        up_d   = up_q;
        down_d = down_q;
      end
      en_s_d = (state_d == STEP) || (state_d == STEP_R);
    end
  end

  // run_prev resets to 1 so reset release with run=1 behaves as an already-running prescaler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      dly_q      <= '0;
      rate_q     <= '0;
      state_q    <= IDLE;
      prev_up_q  <= 1'b0;
      prev_dn_q  <= 1'b0;
      run_prev_q <= 1'b1;
      en_s_q     <= 1'b0;
      up_q       <= 1'b1;
      down_q     <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      dly_q      <= dly_d;
      rate_q     <= rate_d;
      state_q    <= state_d;
      prev_up_q  <= prev_up_d;
      prev_dn_q  <= prev_dn_d;
      run_prev_q <= run_prev_d;
      en_s_q     <= en_s_d;
      up_q       <= up_d;
      down_q     <= down_d;
    end
  end

  assign en_s = en_s_q;
  assign up   = up_q;
  assign down = down_q;

endmodule
